// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Request/acknowledge bus between the fetch stage and instruction memory.
//   IMEM_REQ   : fetch request (master -> slave)
//   IMEM_ADDR  : fetch address, stable while IMEM_REQ=1 (master -> slave)
//   IMEM_ACK   : read data returned this cycle (slave -> master)
//   IMEM_RDATA : instruction word, valid only with IMEM_ACK (slave -> master)
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_ACK,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_ACK,
    output IMEM_RDATA
  );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, handshakes with instruction memory
// and registers the fetched word into the IF/ID boundary.
//   clk, rst_n     : clock, async active-low reset
//   STALL          : hold IF/ID and stop PC advance
//   PCSrc          : taken branch / redirect, priority over STALL
//   BRANCH_TARGET  : redirect address (bits [1:0] forced to 0)
//   imem           : instruction memory bus (master side)
//   INSTR          : registered IF/ID instruction
//   OPCODE         : INSTR[31:26] to the control decoder
//   PC_PLUS4       : registered PC+4 of INSTR
//   IF_VALID       : INSTR holds a live instruction (0 = bubble)
//
// state | meaning
// IDLE  | post-reset, no request; moves to FETCH next edge
// FETCH | request outstanding at PC, waiting for ACK
// HOLD  | word fetched during a stall parked in the hold buffer
// DRAIN | redirect arrived mid-request; waiting to discard the old word
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     STALL,
  input  logic                     PCSrc,
  input  logic [31:0]              BRANCH_TARGET,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              INSTR,
  output logic [5:0]               OPCODE,
  output logic [31:0]              PC_PLUS4,
  output logic                     IF_VALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc_plus4, w_pc_plus4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_hold_instr, w_hold_instr_nxt;
  logic [31:0] r_hold_pc4, w_hold_pc4_nxt;
  logic [31:0] r_pend, w_pend_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_target;

  assign w_pc4    = r_pc + 32'd4;
  assign w_target = BRANCH_TARGET & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_pc_plus4   <= '0;
      r_valid      <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc4   <= '0;
      r_pend       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_pc_plus4   <= w_pc_plus4_nxt;
      r_valid      <= w_valid_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc4   <= w_hold_pc4_nxt;
      r_pend       <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_pc_plus4_nxt   = r_pc_plus4;
    w_valid_nxt      = r_valid;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc4_nxt   = r_hold_pc4;
    w_pend_nxt       = r_pend;

    // Flush inserts a nop bubble regardless of state or STALL.
    if (PCSrc) begin
      w_instr_nxt = '0;
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        if (PCSrc) w_pc_nxt = w_target;
      end

      FETCH: begin
        if (PCSrc) begin
          if (imem.IMEM_ACK) begin
            w_pc_nxt = w_target;
          end else begin
            // Memory still owes us a word at the old PC; keep ADDR stable.
            w_pend_nxt  = w_target;
            w_state_nxt = DRAIN;
          end
        end else if (imem.IMEM_ACK) begin
          w_pc_nxt = w_pc4;
          if (STALL) begin
            w_hold_instr_nxt = imem.IMEM_RDATA;
            w_hold_pc4_nxt   = w_pc4;
            w_state_nxt      = HOLD;
          end else begin
            w_instr_nxt    = imem.IMEM_RDATA;
            w_pc_plus4_nxt = w_pc4;
            w_valid_nxt    = 1'b1;
          end
        end
      end

      HOLD: begin
        if (PCSrc) begin
          w_pc_nxt    = w_target;
          w_state_nxt = FETCH;
        end else if (!STALL) begin
          w_instr_nxt    = r_hold_instr;
          w_pc_plus4_nxt = r_hold_pc4;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = FETCH;
        end
      end

      DRAIN: begin
        if (imem.IMEM_ACK) begin
          // A redirect in the same cycle as the drained ACK is the newest.
          w_pc_nxt    = PCSrc ? w_target : r_pend;
          w_state_nxt = FETCH;
        end else if (PCSrc) begin
          w_pend_nxt = w_target;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem.IMEM_REQ  = (r_state == FETCH) || (r_state == DRAIN);
  assign imem.IMEM_ADDR = r_pc;

  assign INSTR    = r_instr;
  assign OPCODE   = r_instr[31:26];
  assign PC_PLUS4 = r_pc_plus4;
  assign IF_VALID = r_valid;

endmodule
